// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM states and mode constants for the SPI serial-SRAM responder.
package spi_ram_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WRSR  = 8'h01;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_RDATA   = 3'd3,
        ST_WDATA   = 3'd4,
        ST_STAT_RD = 3'd5,
        ST_STAT_WR = 3'd6,
        ST_IGNORE  = 3'd7
    } ram_state_t;

    // Opcode to post-command state; status opcodes fall to IGNORE when unsupported.
    function automatic ram_state_t decode_op(input logic [7:0] op, input logic status_en);
        ram_state_t st;
        st = ST_IGNORE;
        if (op == OP_READ || op == OP_WRITE) begin
            st = ST_ADDR;
        end else if (status_en && op == OP_RDSR) begin
            st = ST_STAT_RD;
        end else if (status_en && op == OP_WRSR) begin
            st = ST_STAT_WR;
        end
        return st;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with one-cycle rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sync = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_ram_responder.sv
// 23LC-style SPI SRAM responder (mode 0) with internal byte array.
// SPI_RAM_STATUS_EN enables the mode register (RDSR/WRSR) and byte mode.
module spi_ram_responder #(
    parameter int         ADDR_W   = 10,
    parameter logic [7:0] MODE_RST = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck_ram,
    input  logic       css_ram,
    input  logic       sdo_ram,
    output logic       sdi_ram,
    output logic       active,
    output logic [2:0] state_dbg
);
    import spi_ram_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    logic sck_rise, sck_fall, sck_unused_lvl;
    logic cs_rise, cs_fall, cs_unused_lvl;
    logic mosi, sdo_unused_rise, sdo_unused_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .din(sck_ram),
        .sync(sck_unused_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_css (
        .clk(clk), .rst(rst), .din(css_ram),
        .sync(cs_unused_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sdo (
        .clk(clk), .rst(rst), .din(sdo_ram),
        .sync(mosi), .rise(sdo_unused_rise), .fall(sdo_unused_fall)
    );

    ram_state_t        state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_in_q, shift_in_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic [2:0]        tx_cnt_q, tx_cnt_d;
    logic              op_read_q, op_read_d;
    logic              sdi_q, sdi_d;
    logic              active_q, active_d;
    logic              mem_we;
    logic              byte_mode;
    logic              status_en;
    logic [7:0]        status_byte;
    logic [7:0]        in_byte;
    logic [7:0]        load_byte;
    logic [ADDR_W-1:0] next_addr;

    logic [7:0] mem [0:DEPTH-1];

`ifdef SPI_RAM_STATUS_EN
    logic [7:0] mode_q, mode_d;
    logic       stat_done_q, stat_done_d;

    // Only the first complete byte of a WRSR transaction lands in the mode register.
    always_comb begin
        mode_d      = mode_q;
        stat_done_d = stat_done_q;
        if (state_q == ST_IDLE) begin
            stat_done_d = 1'b0;
        end else if (!cs_rise && state_q == ST_STAT_WR && sck_rise &&
                     bit_cnt_q == 5'd7 && !stat_done_q) begin
            mode_d      = in_byte;
            stat_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_RST;
            stat_done_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            stat_done_q <= stat_done_d;
        end
    end

    assign status_en   = 1'b1;
    assign byte_mode   = (mode_q[7:6] == MODE_BYTE);
    assign status_byte = mode_q;
`else
    // STAT_RD is unreachable in this build; the constant only keeps the mux total.
    assign status_en   = 1'b0;
    assign byte_mode   = 1'b0;
    assign status_byte = MODE_RST;
`endif

    assign in_byte   = {shift_in_q, mosi};
    assign load_byte = (state_q == ST_STAT_RD) ? status_byte : mem[addr_q];
    assign next_addr = byte_mode ? addr_q : addr_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_in_d = shift_in_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        tx_cnt_d   = tx_cnt_q;
        op_read_d  = op_read_q;
        sdi_d      = 1'b0;
        mem_we     = 1'b0;
        // Chip-select release overrides any SCK edge seen in the same cycle.
        if (cs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            tx_cnt_d  = 3'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 5'd0;
                        tx_cnt_d  = 3'd0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        shift_in_d = in_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            state_d   = decode_op(in_byte, status_en);
                            op_read_d = (in_byte == OP_READ);
                        end
                    end
                end
                ST_ADDR: begin
                    // Upper address bits shift out of the top and are dropped.
                    if (sck_rise) begin
                        addr_d    = {addr_q[ADDR_W-2:0], mosi};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            state_d   = op_read_q ? ST_RDATA : ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        shift_in_d = in_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            mem_we    = 1'b1;
                            addr_d    = next_addr;
                        end
                    end
                end
                ST_STAT_WR: begin
                    if (sck_rise) begin
                        shift_in_d = in_byte[6:0];
                        bit_cnt_d  = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                    end
                end
                ST_RDATA, ST_STAT_RD: begin
                    // tx_cnt == 0 marks a byte boundary: fetch and present the MSB.
                    sdi_d = sdi_q;
                    if (sck_fall) begin
                        if (tx_cnt_q == 3'd0) begin
                            sdi_d = load_byte[7];
                            tx_d  = {load_byte[6:0], 1'b0};
                            if (state_q == ST_RDATA) begin
                                addr_d = next_addr;
                            end
                        end else begin
                            sdi_d = tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                        tx_cnt_d = tx_cnt_q + 3'd1;
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 5'd0;
            shift_in_q <= 7'd0;
            addr_q     <= '0;
            tx_q       <= 8'd0;
            tx_cnt_q   <= 3'd0;
            op_read_q  <= 1'b0;
            sdi_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_in_q <= shift_in_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            tx_cnt_q   <= tx_cnt_d;
            op_read_q  <= op_read_d;
            sdi_q      <= sdi_d;
            active_q   <= active_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= in_byte;
        end
    end

    assign sdi_ram   = sdi_q;
    assign active    = active_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: SPI mode-0 master tasks and inline checks per scenario.
module tb_spi_ram_responder;

    localparam logic [2:0] EXP_IDLE   = 3'd0;
    localparam logic [2:0] EXP_ADDR   = 3'd2;
    localparam logic [2:0] EXP_IGNORE = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck_ram = 1'b0;
    logic       css_ram = 1'b1;
    logic       sdo_ram = 1'b0;
    logic       sdi_ram;
    logic       active;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_buf [0:3];

    spi_ram_responder dut (
        .clk(clk), .rst(rst), .sck_ram(sck_ram), .css_ram(css_ram),
        .sdo_ram(sdo_ram), .sdi_ram(sdi_ram), .active(active), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_begin();
        css_ram = 1'b0;
        wait_clks(6);
    endtask

    task automatic cs_end();
        wait_clks(6);
        css_ram = 1'b1;
        wait_clks(6);
    endtask

    // One mode-0 bit: set MOSI, sample MISO just before the rising edge, then drop SCK.
    task automatic spi_bit(input logic b, output logic r);
        sdo_ram = b;
        wait_clks(6);
        r = sdi_ram;
        sck_ram = 1'b1;
        wait_clks(6);
        sck_ram = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], rx[i]);
        end
    endtask

    task automatic spi_cmd_addr(input logic [7:0] op, input logic [23:0] addr, output logic [31:0] rx);
        spi_byte(op, rx[31:24]);
        spi_byte(addr[23:16], rx[23:16]);
        spi_byte(addr[15:8], rx[15:8]);
        spi_byte(addr[7:0], rx[7:0]);
    endtask

    task automatic ram_write1(input logic [23:0] addr, input logic [7:0] d);
        logic [31:0] hdr;
        logic [7:0]  rx;
        cs_begin();
        spi_cmd_addr(8'h02, addr, hdr);
        spi_byte(d, rx);
        cs_end();
    endtask

    task automatic ram_read(input logic [23:0] addr, input int n);
        logic [31:0] hdr;
        cs_begin();
        spi_cmd_addr(8'h03, addr, hdr);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rd_buf[i]);
        end
        cs_end();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(1);
        checks++;
        if (sdi_ram !== 1'b0) begin errors++; $display("FAIL reset_sdi got %b want 0", sdi_ram); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
        checks++;
        if (state_dbg !== EXP_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, EXP_IDLE); end
    endtask

    task automatic test_write_read();
        logic [31:0] hdr;
        logic [7:0]  rx;
        css_ram = 1'b0;
        wait_clks(2);
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL active_early got %b want 0", active); end
        wait_clks(1);
        checks++;
        if (active !== 1'b1) begin errors++; $display("FAIL active_rise got %b want 1", active); end
        wait_clks(3);
        spi_cmd_addr(8'h02, 24'h000010, hdr);
        spi_byte(8'hA5, rx);
        checks++;
        if ({hdr, rx} !== 40'd0) begin errors++; $display("FAIL write_miso got %h want 0", {hdr, rx}); end
        cs_end();
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL active_release got %b want 0", active); end
        ram_read(24'h000010, 1);
        checks++;
        if (rd_buf[0] !== 8'hA5) begin errors++; $display("FAIL read_a5 got %h want a5", rd_buf[0]); end
    endtask

    task automatic test_seq_wrap();
        logic [31:0] hdr;
        logic [7:0]  rx;
        cs_begin();
        spi_cmd_addr(8'h02, 24'h0003FE, hdr);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_byte(8'h33, rx);
        cs_end();
        ram_read(24'h0003FE, 3);
        checks++;
        if (rd_buf[0] !== 8'h11) begin errors++; $display("FAIL seq_b0 got %h want 11", rd_buf[0]); end
        checks++;
        if (rd_buf[1] !== 8'h22) begin errors++; $display("FAIL seq_b1 got %h want 22", rd_buf[1]); end
        checks++;
        if (rd_buf[2] !== 8'h33) begin errors++; $display("FAIL seq_b2 got %h want 33", rd_buf[2]); end
        ram_read(24'h000000, 1);
        checks++;
        if (rd_buf[0] !== 8'h33) begin errors++; $display("FAIL wrap_000 got %h want 33", rd_buf[0]); end
        ram_read(24'hFFFFFF, 1);
        checks++;
        if (rd_buf[0] !== 8'h22) begin errors++; $display("FAIL upper_addr_ignored got %h want 22", rd_buf[0]); end
    endtask

    task automatic test_partial_write();
        logic [31:0] hdr;
        logic        r;
        ram_write1(24'h000020, 8'h3C);
        cs_begin();
        spi_cmd_addr(8'h02, 24'h000020, hdr);
        for (int i = 0; i < 5; i++) begin
            spi_bit(1'b1, r);
        end
        cs_end();
        ram_read(24'h000020, 1);
        checks++;
        if (rd_buf[0] !== 8'h3C) begin errors++; $display("FAIL partial_write got %h want 3c", rd_buf[0]); end
    endtask

    task automatic test_ignore();
        logic [7:0] rx0, rx1, rx2;
        cs_begin();
        spi_byte(8'h9F, rx0);
        spi_byte(8'hFF, rx1);
        checks++;
        if (state_dbg !== EXP_IGNORE) begin errors++; $display("FAIL ignore_state got %0d want %0d", state_dbg, EXP_IGNORE); end
        spi_byte(8'hFF, rx2);
        cs_end();
        checks++;
        if ({rx0, rx1, rx2} !== 24'd0) begin errors++; $display("FAIL ignore_miso got %h want 0", {rx0, rx1, rx2}); end
        ram_read(24'h000010, 1);
        checks++;
        if (rd_buf[0] !== 8'hA5) begin errors++; $display("FAIL ignore_mem got %h want a5", rd_buf[0]); end
    endtask

`ifdef SPI_RAM_STATUS_EN
    task automatic test_status();
        logic [7:0]  rx0, rx1;
        logic [31:0] hdr;
        cs_begin();
        spi_byte(8'h05, rx0);
        spi_byte(8'h00, rx0);
        spi_byte(8'h00, rx1);
        cs_end();
        checks++;
        if (rx0 !== 8'h40) begin errors++; $display("FAIL rdsr_first got %h want 40", rx0); end
        checks++;
        if (rx1 !== 8'h40) begin errors++; $display("FAIL rdsr_repeat got %h want 40", rx1); end
        cs_begin();
        spi_byte(8'h01, rx0);
        spi_byte(8'h00, rx0);
        spi_byte(8'hC0, rx0);
        cs_end();
        cs_begin();
        spi_cmd_addr(8'h02, 24'h000030, hdr);
        spi_byte(8'h5A, rx0);
        spi_byte(8'h6B, rx0);
        cs_end();
        ram_read(24'h000030, 2);
        checks++;
        if (rd_buf[0] !== 8'h6B) begin errors++; $display("FAIL byte_mode_b0 got %h want 6b", rd_buf[0]); end
        checks++;
        if (rd_buf[1] !== 8'h6B) begin errors++; $display("FAIL byte_mode_b1 got %h want 6b", rd_buf[1]); end
    endtask
`else
    task automatic test_no_status();
        logic [7:0] rx0, rx1;
        cs_begin();
        spi_byte(8'h05, rx0);
        spi_byte(8'h00, rx1);
        checks++;
        if (state_dbg !== EXP_IGNORE) begin errors++; $display("FAIL rdsr_ignored_state got %0d want %0d", state_dbg, EXP_IGNORE); end
        cs_end();
        checks++;
        if (rx1 !== 8'h00) begin errors++; $display("FAIL rdsr_ignored_miso got %h want 00", rx1); end
    endtask
`endif

    task automatic test_rst_mid();
        logic [7:0] rx;
        logic       r;
        cs_begin();
        spi_byte(8'h03, rx);
        for (int i = 0; i < 12; i++) begin
            spi_bit(1'b0, r);
        end
        checks++;
        if (state_dbg !== EXP_ADDR) begin errors++; $display("FAIL pre_rst_state got %0d want %0d", state_dbg, EXP_ADDR); end
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        checks++;
        if (state_dbg !== EXP_IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", state_dbg, EXP_IDLE); end
        checks++;
        if (sdi_ram !== 1'b0) begin errors++; $display("FAIL rst_sdi got %b want 0", sdi_ram); end
        cs_end();
        ram_read(24'h000010, 2);
        checks++;
        if (rd_buf[0] !== 8'hA5) begin errors++; $display("FAIL post_rst_read got %h want a5", rd_buf[0]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_seq_wrap();
        test_partial_write();
        test_ignore();
`ifdef SPI_RAM_STATUS_EN
        test_status();
`else
        test_no_status();
`endif
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_responder.md
# spi_ram_responder

Synthesizable SPI serial-SRAM responder: the memory end of the `delay_core` RAM link (`sck_ram`, `css_ram`, `sdi_ram`, `sdo_ram`). It decodes 23LC-style READ/WRITE commands from the core, stores bytes in an internal array, and shifts read data back on `sdi_ram`. It replaces the fixed `sdi_ram` tie in system benches and stands in for the external SRAM in FPGA loopback builds.

## Interface
- `ADDR_W`, 10: internal address width; depth is 2^ADDR_W bytes.
- `MODE_RST`, 8'h40: reset value of the mode register (sequential mode).
- `clk`  in  1  system clock; the same clock that drives `delay_core`.
- `rst`  in  1  reset, synchronous, active-high.
- `sck_ram`  in  1  SPI clock from the core; mode 0.
- `css_ram`  in  1  chip select from the core, active-low.
- `sdo_ram`  in  1  serial data from the core (core → RAM).
- `sdi_ram`  out  1  serial data to the core (RAM → core); always driven, never tristated.
- `active`  out  1  high while a selected transaction is in progress.

## Operation
- `sck_ram`, `css_ram` and `sdo_ram` each pass through a 2-flop synchronizer.
  - Rising and falling edges of `sck_ram` are detected from the synchronized copies.
- MOSI (`sdo_ram`) is sampled on `sck_ram` rising edges. MSB is first.
- Commands:
  - 8'h03 READ: 24 address bits, then data out.
  - 8'h02 WRITE: 24 address bits, then data in.
  - 8'h05 RDSR: read the mode register.
  - 8'h01 WRSR: write the mode register.
- Only the low `ADDR_W` bits of the 24-bit address are used. Upper bits are ignored.
- FSM states:
  - IDLE → CMD on synchronized `css_ram` falling.
  - CMD → ADDR (READ/WRITE), STAT_RD, STAT_WR, or IGNORE (any other opcode), after 8 bits.
  - ADDR → RDATA or WDATA after 24 bits.
  - RDATA, WDATA, STAT_RD and STAT_WR remain until chip select is released.
  - Any state → IDLE on synchronized `css_ram` rising.
- WDATA:
  - Each completed 8-bit byte is written to `mem[addr]`, then the address advances.
  - A partial byte at CS release is discarded.
- RDATA:
  - On the `sck_ram` falling edge after the last address bit, `mem[addr]` is loaded into the shift register.
  - One bit is shifted out per subsequent falling edge. The next byte is loaded after every 8th bit.
- Address advance: increment modulo 2^ADDR_W (0x3FF → 0x000 at the default width).
  - In byte mode (mode[7:6] = 2'b00) the address does not advance. The same location is rewritten or reread.
- STAT_WR: the first complete byte is stored in the mode register. Later bytes are ignored.
- STAT_RD: the mode register is shifted out repeatedly.
- `sdi_ram` is 0 in IDLE, CMD, ADDR, IGNORE and the write states.

## Timing
- Reset values:
  - `sdi_ram` = 0, `active` = 0, FSM = IDLE.
  - mode = `MODE_RST`, bit counters = 0.
  - Memory contents are not reset.
- `sdi_ram` updates 3 `clk` cycles after a physical `sck_ram` falling edge (2 synchronizer flops + 1 output register).
- Input sampling acts 3 `clk` cycles after a physical rising edge.
- Requirement on the initiator: `sck_ram` high and low phases ≥ 4 `clk` cycles each. `sdo_ram` must be stable ≥ 3 cycles around the rising edge.
- `active` asserts 3 cycles after `css_ram` falls and deasserts 3 cycles after it rises.
- A write commits on the `clk` cycle after the 8th sampled bit. A read in the same transaction sees the new value.
- `rst` mid-transaction: return to IDLE and drop the partial byte. Memory is kept; the mode register is reset.
- `css_ram` rising on the same cycle as an `sck_ram` edge: chip-select release wins and the edge is ignored.

## Configuration
- `SPI_RAM_STATUS_EN` defined: RDSR, WRSR and byte mode are supported as described above.
- Undefined:
  - No mode register exists and sequential mode is fixed.
  - 8'h01 and 8'h05 decode to IGNORE.

## Structure
- Package `spi_ram_pkg`:
  - Opcode localparams `OP_READ`, `OP_WRITE`, `OP_RDSR`, `OP_WRSR`.
  - State enum `ram_state_t`.
  - `MODE_BYTE` / `MODE_SEQ` constants.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall pulse outputs. Instantiated for `sck_ram`, `css_ram` and `sdo_ram`.
- Memory is an inferred single-port byte array in the top module.

## Test plan
- WRITE 0xA5 to address 0x000010, then READ 0x000010 → `sdi_ram` shifts 1010_0101. `active` is high only during CS low.
- Sequential WRITE 0x11, 0x22, 0x33 starting at 0x0003FE, then READ 3 bytes at 0x0003FE → 0x11, 0x22, 0x33. Wrap 0x3FF → 0x000 is verified with a read at 0x000.
- WRITE to 0x000020 with CS released after 5 data bits → the prior contents of 0x20 are unchanged on readback.
- (STATUS_EN) RDSR after reset → 0x40. WRSR 0x00, then WRITE 0x5A, 0x6B at 0x30 → READ of 2 bytes returns 0x6B, 0x6B.
- Opcode 0x9F followed by 16 clocks → `sdi_ram` stays 0 and memory is untouched.
- `rst` pulsed after 12 address bits of a READ → FSM is IDLE, `sdi_ram` is 0, and the next full READ completes correctly.
